// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick used by the
// four-way round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam int NUM_REQ = 4;

    // Returns {found, index}; search starts at ptr and wraps mod 4.
    function automatic logic [2:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [1:0]         ptr
    );
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// Four-input N-bit multiplexer driven by an encoded select.
module mux4 #(
    parameter int N = 16
) (
    input  logic [1:0]   s,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [N-1:0] y
);

    always_comb begin
        unique case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared N-bit port with a per-tenure beat
// limit; the data path is only the mux4 steered by the registered sel.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic         res_ready,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic [N-1:0] y,
    output logic         y_valid,
    output logic         beat
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        r_state;
    logic [3:0]    r_grant;
    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [HW-1:0] r_hold;

    logic          w_busy;
    logic          w_owner_req;
    logic          w_last_beat;
    logic          w_release;
    logic [1:0]    w_ptr_next;
    logic [2:0]    w_pick;
    logic          w_found;
    logic [1:0]    w_win;

    assign w_busy      = (r_state == BUSY);
    assign w_owner_req = req[r_sel];
    assign y_valid     = w_busy & w_owner_req;
    assign beat        = y_valid & res_ready;
    assign w_last_beat = beat & (r_hold == HOLD_LAST);
    assign w_release   = w_busy & (~w_owner_req | w_last_beat);

    // On release the old owner drops to lowest priority for this pick.
    assign w_ptr_next  = w_release ? r_sel + 2'd1 : r_ptr;
    assign w_pick      = rr_pick(req, w_ptr_next);
    assign w_found     = w_pick[2];
    assign w_win       = w_pick[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_hold  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_grant <= 4'b0001 << w_win;
                        r_sel   <= w_win;
                        r_hold  <= '0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr  <= w_ptr_next;
                        r_hold <= '0;
                        if (w_found) begin
                            r_grant <= 4'b0001 << w_win;
                            r_sel   <= w_win;
                        end else begin
                            r_grant <= 4'b0000;
                            r_state <= IDLE;
                        end
                    end else if (beat) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;

    mux4 #(
        .N(N)
    ) u_mux4 (
        .s (r_sel),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3),
        .y (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomised and directed bench for mux4_rr_arbiter: two instances
// (MAX_HOLD 8 and 2) share stimulus and are tracked by tenure models.
module tb_mux4_rr_arbiter;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [N-1:0] d0, d1, d2, d3;
    logic         res_ready;

    logic [3:0]   grant8, grant2;
    logic [1:0]   sel8, sel2;
    logic [N-1:0] y8, y2;
    logic         yv8, yv2, beat8, beat2;

    int n_chk = 0;
    int n_err = 0;

    int mh[2]      = '{8, 2};
    int m_owner[2];
    int m_sel[2];
    int m_ptr[2];
    int m_beats[2];

    mux4_rr_arbiter #(.N(N), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset(reset), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .res_ready(res_ready), .grant(grant8), .sel(sel8),
        .y(y8), .y_valid(yv8), .beat(beat8)
    );

    mux4_rr_arbiter #(.N(N), .MAX_HOLD(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .res_ready(res_ready), .grant(grant2), .sel(sel2),
        .y(y2), .y_valid(yv2), .beat(beat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] dsel(input int s);
        case (s)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_beats[i] = 0;
        end
    endtask

    task automatic model_step();
        int  w;
        bit  live, rel;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_owner[i] = -1; m_sel[i] = 0;
                m_ptr[i] = 0; m_beats[i] = 0;
            end else if (m_owner[i] < 0) begin
                w = pick(req, m_ptr[i]);
                if (w >= 0) begin
                    m_owner[i] = w; m_sel[i] = w; m_beats[i] = 0;
                end
            end else begin
                live = req[m_owner[i]] && res_ready;
                if (live) m_beats[i]++;
                rel = !req[m_owner[i]] || (m_beats[i] == mh[i]);
                if (rel) begin
                    m_ptr[i] = (m_owner[i] + 1) % 4;
                    w = pick(req, m_ptr[i]);
                    m_beats[i] = 0;
                    m_owner[i] = w;
                    if (w >= 0) m_sel[i] = w;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        bit         ev;
        for (int i = 0; i < 2; i++) begin
            eg = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
            ev = (m_owner[i] >= 0) && req[m_owner[i]];
            if (i == 0) begin
                chk("grant8", 32'(grant8), 32'(eg));
                chk("sel8", 32'(sel8), 32'(m_sel[0]));
                chk("y8", 32'(y8), 32'(dsel(m_sel[0])));
                chk("yv8", 32'(yv8), 32'(ev));
                chk("beat8", 32'(beat8), 32'(ev && res_ready));
            end else begin
                chk("grant2", 32'(grant2), 32'(eg));
                chk("sel2", 32'(sel2), 32'(m_sel[1]));
                chk("y2", 32'(y2), 32'(dsel(m_sel[1])));
                chk("yv2", 32'(yv2), 32'(ev));
                chk("beat2", 32'(beat2), 32'(ev && res_ready));
            end
        end
    endtask

    // Drive on negedge, check before the edge, advance model on it.
    task automatic cycle(input logic [3:0] r, input logic rdy,
                         input logic rst);
        @(negedge clk);
        req       = r;
        res_ready = rdy;
        reset     = rst;
        d0 = N'($urandom); d1 = N'($urandom);
        d2 = N'($urandom); d3 = N'($urandom);
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #2;
    endtask

    int nb;
    int exp_rot[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        reset = 1'b1; req = 4'b0; res_ready = 1'b0;
        d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333; d3 = 16'h4444;
        model_reset();
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        chk("rst_grant", 32'(grant8), 32'h0);
        chk("rst_sel", 32'(sel8), 32'h0);
        chk("rst_yv", 32'(yv8), 32'h0);

        // single requester 2: 8 beats, forced release, re-grant
        cycle(4'b0100, 1'b1, 1'b0);
        chk("s1_grant", 32'(grant8), 32'h4);
        chk("s1_sel", 32'(sel8), 32'h2);
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(4'b0100, 1'b1, 1'b0);
            nb += (k < 8) ? 1 : 0;
        end
        chk("s1_regrant", 32'(grant8), 32'h4);
        cycle(4'b0000, 1'b0, 1'b1);

        // all requesting, MAX_HOLD=2 instance rotates 0,1,2,3,0
        for (int k = 0; k < 10; k++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            chk("rot_sel2", 32'(sel2), 32'(exp_rot[k]));
            chk("rot_busy2", 32'(grant2 != 4'b0), 32'h1);
        end
        cycle(4'b0000, 1'b0, 1'b1);

        // owner 1 drops after 3 beats, 0 and 3 pending -> 3 wins
        cycle(4'b0010, 1'b1, 1'b0);
        chk("s3_grant1", 32'(grant8), 32'h2);
        for (int k = 0; k < 3; k++) cycle(4'b1011, 1'b1, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0);
        chk("s3_grant3", 32'(grant8), 32'h8);
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1001, 1'b1, 1'b0);
            if (k < 7) chk("s3_hold", 32'(grant8), 32'h8);
        end
        chk("s3_rotate0", 32'(grant8), 32'h1);
        cycle(4'b0000, 1'b0, 1'b1);

        // stalled resource: grant held, no beats
        cycle(4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            chk("s4_grant", 32'(grant8), 32'h1);
        end
        nb = 0;
        for (int k = 0; k < 12 && nb < 8; k++) begin
            @(negedge clk);
            cycle(4'b0001, 1'b1, 1'b0);
            nb++;
        end
        chk("s4_beats", 32'(nb), 32'd8);
        cycle(4'b0000, 1'b0, 1'b1);

        // reset mid-tenure, then ptr restarts at 0
        cycle(4'b0010, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(4'b0010, 1'b1, 1'b0);
        chk("s5_pre", 32'(grant8), 32'h2);
        cycle(4'b0010, 1'b1, 1'b1);
        chk("s5_grant", 32'(grant8), 32'h0);
        chk("s5_sel", 32'(sel8), 32'h0);
        chk("s5_yv", 32'(yv8), 32'h0);
        cycle(4'b0011, 1'b1, 1'b0);
        chk("s5_win0", 32'(grant8), 32'h1);

        // random run
        for (int k = 0; k < 600; k++) begin
            cycle(4'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
